// File: rtl/vert_ucode_quicksort_fetch.sv
// ---------------------------------------------------------------------------
// vert_ucode_quicksort_fetch
//
// Microcode fetch stage for the vertical-microcode quicksort engine. It sits
// directly upstream of instruction decode. The block owns the PC, issues
// reads to the synchronous ucode ROM, and buffers the returned instructions
// in a 2-entry skid FIFO. Decode receives them over a valid/ready handshake.
// Execute can redirect the PC (taken JCC, CALL, RET). A redirect squashes
// every wrong-path fetch.
//
// Parameters
//   PC_W      PC / ROM address width
//   INST_W    instruction width
//   RESET_PC  PC loaded at reset
//
// Ports
//   clk           in   clock, sole clock domain
//   rst           in   synchronous active-high reset
//   fetch_en      in   permit new ROM reads; low = drain in-flight only
//   rom_en        out  ROM read strobe
//   rom_addr      out  ROM read address (current PC)
//   rom_rdata     in   ROM data, valid the cycle after rom_en
//   redirect_vld  in   taken control transfer from execute
//   redirect_pc   in   redirect target
//   fetch_vld     out  instruction available to decode (FIFO head valid)
//   fetch_inst    out  instruction at FIFO head
//   fetch_pc      out  PC of fetch_inst
//   fetch_rdy     in   decode accepts the head this cycle
// ---------------------------------------------------------------------------
module vert_ucode_quicksort_fetch #(
  parameter int              PC_W     = 8,
  parameter int              INST_W   = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic              rom_en,
  output logic [PC_W-1:0]   rom_addr,
  input  logic [INST_W-1:0] rom_rdata,
  input  logic              redirect_vld,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              fetch_vld,
  output logic [INST_W-1:0] fetch_inst,
  output logic [PC_W-1:0]   fetch_pc,
  input  logic              fetch_rdy
);

  // RUN: normal operation. FLUSH: the cycle after a redirect. Any ROM data
  // seen in FLUSH belongs to the old path and is ignored.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t            state_q,       state_d;
  logic [PC_W-1:0]   pc_q,          pc_d;
  logic              inflight_q,    inflight_d;
  logic [PC_W-1:0]   inflight_pc_q, inflight_pc_d;
  logic [1:0]        count_q,       count_d;
  logic [INST_W-1:0] inst0_q,       inst0_d;
  logic [PC_W-1:0]   pc0_q,         pc0_d;
  logic [INST_W-1:0] inst1_q,       inst1_d;
  logic [PC_W-1:0]   pc1_q,         pc1_d;

  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        occupancy;
  logic [2:0]        credit_limit;

  // Handshake and credit accounting. The credit check counts every entry
  // the FIFO will hold once the in-flight read lands. An entry popped this
  // cycle frees its slot immediately, so streaming reaches 1 inst/cycle.
  always_comb begin
    pop          = (count_q != 2'd0) && fetch_rdy;
    push         = inflight_q && (state_q == ST_RUN);
    occupancy    = {1'b0, count_q} + {2'b00, inflight_q};
    credit_limit = 3'd2 + {2'b00, pop};
    issue        = !rst && fetch_en && !redirect_vld && (occupancy < credit_limit);
  end

  // Next-state logic for the PC, the in-flight tracker, the FIFO and the
  // FSM. A redirect overrides everything: it empties the FIFO, forgets the
  // pending read and loads the target PC. Any handshake in the same cycle
  // is void, so the FIFO head is not popped.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    inst0_d       = inst0_q;
    pc0_d         = pc0_q;
    inst1_d       = inst1_q;
    pc1_d         = pc1_q;

    if (redirect_vld) begin
      state_d    = ST_FLUSH;
      pc_d       = redirect_pc;
      inflight_d = 1'b0;
      count_d    = 2'd0;
    end else begin
      state_d    = ST_RUN;
      inflight_d = issue;
      if (issue) begin
        inflight_pc_d = pc_q;
        pc_d          = pc_q + PC_ONE;
      end

      // Shift FIFO: entry 0 is always the head, so the outputs come
      // straight from flops.
      unique case ({push, pop})
        2'b11: begin
          if (count_q == 2'd2) begin
            inst0_d = inst1_q;
            pc0_d   = pc1_q;
            inst1_d = rom_rdata;
            pc1_d   = inflight_pc_q;
          end else begin
            inst0_d = rom_rdata;
            pc0_d   = inflight_pc_q;
          end
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            inst0_d = rom_rdata;
            pc0_d   = inflight_pc_q;
          end else begin
            inst1_d = rom_rdata;
            pc1_d   = inflight_pc_q;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          inst0_d = inst1_q;
          pc0_d   = pc1_q;
          count_d = count_q - 2'd1;
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  // Control state. Reset also discards any read in flight, so its data is
  // never pushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
    end
  end

  // Datapath storage. These registers are only meaningful while the
  // control state marks them valid, so they do not need a reset.
  always_ff @(posedge clk) begin
    inflight_pc_q <= inflight_pc_d;
    inst0_q       <= inst0_d;
    pc0_q         <= pc0_d;
    inst1_q       <= inst1_d;
    pc1_q         <= pc1_d;
  end

  assign rom_en     = issue;
  assign rom_addr   = pc_q;
  assign fetch_vld  = (count_q != 2'd0);
  assign fetch_inst = inst0_q;
  assign fetch_pc   = pc0_q;

  // The credit rule guarantees that a full FIFO only accepts a push while it
  // is popping.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (push && !redirect_vld && (count_q == 2'd2)) |-> pop);

  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, count_q} + {2'b00, inflight_q}) <= 3'd2);

  // A presented instruction must hold until it is accepted or squashed.
  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (fetch_vld && !fetch_rdy && !redirect_vld) |=>
      (fetch_vld && $stable(fetch_inst) && $stable(fetch_pc)));

endmodule

// File: tb/tb_vert_ucode_quicksort_fetch.sv
// ---------------------------------------------------------------------------
// tb_vert_ucode_quicksort_fetch
//
// Directed bench for the ucode fetch stage. The synchronous ROM model
// returns 16'h1000 + address one cycle after rom_en. Expected PCs and
// instructions are hand-derived constants per cycle.
//
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled
// on the falling edge.
// ---------------------------------------------------------------------------
module tb_vert_ucode_quicksort_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        rom_en;
  logic [7:0]  rom_addr;
  logic [15:0] rom_rdata;
  logic        redirect_vld;
  logic [7:0]  redirect_pc;
  logic        fetch_vld;
  logic [15:0] fetch_inst;
  logic [7:0]  fetch_pc;
  logic        fetch_rdy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vert_ucode_quicksort_fetch #(.PC_W(8), .INST_W(16), .RESET_PC(8'h00)) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_en     (fetch_en),
    .rom_en       (rom_en),
    .rom_addr     (rom_addr),
    .rom_rdata    (rom_rdata),
    .redirect_vld (redirect_vld),
    .redirect_pc  (redirect_pc),
    .fetch_vld    (fetch_vld),
    .fetch_inst   (fetch_inst),
    .fetch_pc     (fetch_pc),
    .fetch_rdy    (fetch_rdy)
  );

  // Synchronous ROM: ROM[i] = 16'h1000 + i. Unread cycles return junk, so
  // data that is wrongly pushed shows up in the checks.
  always @(posedge clk) begin
    if (rom_en === 1'b1) rom_rdata <= 16'h1000 + {8'h00, rom_addr};
    else                 rom_rdata <= 16'hDEAD;
  end

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; fetch_en = 1'b1; fetch_rdy = 1'b1;
    redirect_vld = 1'b0; redirect_pc = 8'h00;
    advance();
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_en = 1'b1; fetch_rdy = 1'b1;
    redirect_vld = 1'b0; redirect_pc = 8'h00;
    advance();
    @(negedge clk);
    vectors++;
    if (rom_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rom_en: got %b want 0", rom_en); end
    vectors++;
    if (fetch_vld !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_fetch_vld: got %b want 0", fetch_vld); end
    advance();
    rst = 1'b0; fetch_en = 1'b0;
    @(negedge clk);
    vectors++;
    if (rom_en !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_rom_en: got %b want 0", rom_en); end
    vectors++;
    if (fetch_vld !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_fetch_vld: got %b want 0", fetch_vld); end
    advance();
  endtask

  task automatic test_stream();
    logic [7:0]  ea;
    logic [7:0]  ep;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      ea = 8'(k);
      ep = 8'(k - 2);
      @(negedge clk);
      vectors++;
      if (rom_en !== 1'b1 || rom_addr !== ea) begin
        miscompares++; $display("[TB] FAIL stream_rom c%0d: got en=%b addr=%h want en=1 addr=%h", k, rom_en, rom_addr, ea);
      end
      vectors++;
      if (k >= 2) begin
        if (fetch_vld !== 1'b1 || fetch_pc !== ep || fetch_inst !== (16'h1000 + {8'h00, ep})) begin
          miscompares++; $display("[TB] FAIL stream_out c%0d: got vld=%b pc=%h inst=%h want vld=1 pc=%h inst=%h", k, fetch_vld, fetch_pc, fetch_inst, ep, 16'h1000 + {8'h00, ep});
        end
      end else if (fetch_vld !== 1'b0) begin
        miscompares++; $display("[TB] FAIL stream_latency c%0d: got vld=%b want 0", k, fetch_vld);
      end
      advance();
    end
  endtask

  task automatic test_stall();
    logic [7:0] ea;
    logic [7:0] ep;
    do_reset();
    for (int k = 0; k < 4; k++) advance();
    fetch_rdy = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      vectors++;
      if (rom_en !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_rom_en s%0d: got %b want 0", j, rom_en); end
      vectors++;
      if (fetch_vld !== 1'b1 || fetch_pc !== 8'h02 || fetch_inst !== 16'h1002) begin
        miscompares++; $display("[TB] FAIL stall_hold s%0d: got vld=%b pc=%h inst=%h want vld=1 pc=02 inst=1002", j, fetch_vld, fetch_pc, fetch_inst);
      end
      advance();
    end
    fetch_rdy = 1'b1;
    for (int j = 0; j < 5; j++) begin
      ea = 8'(4 + j);
      ep = 8'(2 + j);
      @(negedge clk);
      vectors++;
      if (rom_en !== 1'b1 || rom_addr !== ea) begin
        miscompares++; $display("[TB] FAIL resume_rom r%0d: got en=%b addr=%h want en=1 addr=%h", j, rom_en, rom_addr, ea);
      end
      vectors++;
      if (fetch_vld !== 1'b1 || fetch_pc !== ep || fetch_inst !== (16'h1000 + {8'h00, ep})) begin
        miscompares++; $display("[TB] FAIL resume_out r%0d: got vld=%b pc=%h inst=%h want pc=%h", j, fetch_vld, fetch_pc, fetch_inst, ep);
      end
      advance();
    end
  endtask

  // Redirect while one entry is buffered and one read is in flight. Decode
  // is ready in the redirect cycle, so that handshake is void. The target
  // is issued the next cycle and appears two cycles after that issue.
  task automatic test_redirect();
    logic [7:0] ea;
    logic [7:0] ep;
    do_reset();
    for (int k = 0; k < 4; k++) advance();
    redirect_vld = 1'b1; redirect_pc = 8'h40;
    @(negedge clk);
    vectors++;
    if (rom_en !== 1'b0) begin miscompares++; $display("[TB] FAIL redir_rom_en: got %b want 0", rom_en); end
    advance();
    redirect_vld = 1'b0;
    for (int j = 0; j < 5; j++) begin
      ea = 8'h40 + 8'(j);
      ep = 8'h40 + 8'(j) - 8'd2;
      @(negedge clk);
      vectors++;
      if (rom_en !== 1'b1 || rom_addr !== ea) begin
        miscompares++; $display("[TB] FAIL redir_rom r%0d: got en=%b addr=%h want en=1 addr=%h", j, rom_en, rom_addr, ea);
      end
      vectors++;
      if (j >= 2) begin
        if (fetch_vld !== 1'b1 || fetch_pc !== ep || fetch_inst !== (16'h1000 + {8'h00, ep})) begin
          miscompares++; $display("[TB] FAIL redir_out r%0d: got vld=%b pc=%h inst=%h want pc=%h", j, fetch_vld, fetch_pc, fetch_inst, ep);
        end
      end else if (fetch_vld !== 1'b0) begin
        miscompares++; $display("[TB] FAIL redir_stale r%0d: got vld=%b pc=%h want vld=0", j, fetch_vld, fetch_pc);
      end
      advance();
    end
  endtask

  task automatic test_wrap();
    logic [7:0] ea;
    logic [7:0] ep;
    do_reset();
    redirect_vld = 1'b1; redirect_pc = 8'hFE;
    @(negedge clk);
    vectors++;
    if (rom_en !== 1'b0) begin miscompares++; $display("[TB] FAIL wrap_rom_en: got %b want 0", rom_en); end
    advance();
    redirect_vld = 1'b0;
    for (int j = 0; j < 6; j++) begin
      ea = 8'hFE + 8'(j);
      ep = 8'hFE + 8'(j) - 8'd2;
      @(negedge clk);
      vectors++;
      if (rom_en !== 1'b1 || rom_addr !== ea) begin
        miscompares++; $display("[TB] FAIL wrap_rom w%0d: got en=%b addr=%h want en=1 addr=%h", j, rom_en, rom_addr, ea);
      end
      if (j >= 2) begin
        vectors++;
        if (fetch_vld !== 1'b1 || fetch_pc !== ep || fetch_inst !== (16'h1000 + {8'h00, ep})) begin
          miscompares++; $display("[TB] FAIL wrap_out w%0d: got vld=%b pc=%h inst=%h want pc=%h", j, fetch_vld, fetch_pc, fetch_inst, ep);
        end
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ea;
    logic [7:0] ep;
    do_reset();
    for (int k = 0; k < 3; k++) advance();
    redirect_vld = 1'b1; redirect_pc = 8'h10;
    @(negedge clk);
    vectors++;
    if (rom_en !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_first_rom_en: got %b want 0", rom_en); end
    advance();
    redirect_pc = 8'h20;
    @(negedge clk);
    vectors++;
    if (rom_en !== 1'b0 || fetch_vld !== 1'b0) begin
      miscompares++; $display("[TB] FAIL b2b_second: got en=%b vld=%b want en=0 vld=0", rom_en, fetch_vld);
    end
    advance();
    redirect_vld = 1'b0;
    for (int j = 0; j < 4; j++) begin
      ea = 8'h20 + 8'(j);
      ep = 8'h20 + 8'(j) - 8'd2;
      @(negedge clk);
      vectors++;
      if (rom_en !== 1'b1 || rom_addr !== ea) begin
        miscompares++; $display("[TB] FAIL b2b_rom b%0d: got en=%b addr=%h want en=1 addr=%h", j, rom_en, rom_addr, ea);
      end
      vectors++;
      if (j >= 2) begin
        if (fetch_vld !== 1'b1 || fetch_pc !== ep) begin
          miscompares++; $display("[TB] FAIL b2b_out b%0d: got vld=%b pc=%h want vld=1 pc=%h", j, fetch_vld, fetch_pc, ep);
        end
      end else if (fetch_vld !== 1'b0) begin
        miscompares++; $display("[TB] FAIL b2b_stale b%0d: got vld=%b pc=%h want vld=0", j, fetch_vld, fetch_pc);
      end
      advance();
    end
  endtask

  task automatic test_fetch_en_drain();
    do_reset();
    for (int k = 0; k < 3; k++) advance();
    fetch_en = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      vectors++;
      if (rom_en !== 1'b0) begin miscompares++; $display("[TB] FAIL drain_rom_en d%0d: got %b want 0", j, rom_en); end
      vectors++;
      if (j < 2) begin
        if (fetch_vld !== 1'b1 || fetch_pc !== 8'(1 + j)) begin
          miscompares++; $display("[TB] FAIL drain_out d%0d: got vld=%b pc=%h want vld=1 pc=%h", j, fetch_vld, fetch_pc, 8'(1 + j));
        end
      end else if (fetch_vld !== 1'b0) begin
        miscompares++; $display("[TB] FAIL drain_empty d%0d: got vld=%b want 0", j, fetch_vld);
      end
      advance();
    end
    fetch_en = 1'b1;
    @(negedge clk);
    vectors++;
    if (rom_en !== 1'b1 || rom_addr !== 8'h03) begin
      miscompares++; $display("[TB] FAIL drain_restart: got en=%b addr=%h want en=1 addr=03", rom_en, rom_addr);
    end
    advance();
  endtask

  // Reset while one entry is buffered and the next read is landing. The
  // landed data must be dropped, and fetch must restart from address 0.
  task automatic test_reset_midstream();
    logic [7:0] ea;
    do_reset();
    for (int k = 0; k < 4; k++) advance();
    fetch_rdy = 1'b0; rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (rom_en !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_rom_en: got %b want 0", rom_en); end
    advance();
    rst = 1'b0; fetch_en = 1'b0;
    @(negedge clk);
    vectors++;
    if (fetch_vld !== 1'b0 || rom_en !== 1'b0) begin
      miscompares++; $display("[TB] FAIL rstmid_after: got vld=%b en=%b want vld=0 en=0", fetch_vld, rom_en);
    end
    advance();
    fetch_en = 1'b1; fetch_rdy = 1'b1;
    for (int j = 0; j < 3; j++) begin
      ea = 8'(j);
      @(negedge clk);
      vectors++;
      if (rom_en !== 1'b1 || rom_addr !== ea) begin
        miscompares++; $display("[TB] FAIL rstmid_rom m%0d: got en=%b addr=%h want en=1 addr=%h", j, rom_en, rom_addr, ea);
      end
      vectors++;
      if (j == 2) begin
        if (fetch_vld !== 1'b1 || fetch_pc !== 8'h00 || fetch_inst !== 16'h1000) begin
          miscompares++; $display("[TB] FAIL rstmid_out: got vld=%b pc=%h inst=%h want vld=1 pc=00 inst=1000", fetch_vld, fetch_pc, fetch_inst);
        end
      end else if (fetch_vld !== 1'b0) begin
        miscompares++; $display("[TB] FAIL rstmid_drop m%0d: got vld=%b pc=%h want vld=0", j, fetch_vld, fetch_pc);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_back_to_back();
    test_fetch_en_drain();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
